// File: rtl/shift_in_pkg.sv
// Shared definitions for the multiplier's bit-serial product link.
// Used by both the product serializer and the shift_in receiver.
package shift_in_pkg;

    localparam int LINK_WIDTH = 24;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] RECV  = 2'b01;
    localparam logic [1:0] FULL  = 2'b10;
    localparam logic [1:0] DRAIN = 2'b11;

    // MSB-first accumulation: the newest bit enters at the LSB end.
    function automatic logic [31:0] shift_msb_first(input logic [31:0] word, input logic b);
        return {word[30:0], b};
    endfunction

endpackage

// File: rtl/shift_in_if.sv
// Bit-serial link bundle: the serial pair in, the received word and status pulses out.
interface shift_in_if
    import shift_in_pkg::*;
#(
    parameter int WIDTH = LINK_WIDTH
);
    logic             z_in;
    logic             fz_in;
    logic [WIDTH-1:0] data_out;
    logic             valid;
    logic             busy;
    logic             err_short;
    logic             err_overrun;

    modport master (
        output z_in, fz_in,
        input  data_out, valid, busy, err_short, err_overrun
    );

    modport slave (
        input  z_in, fz_in,
        output data_out, valid, busy, err_short, err_overrun
    );
endinterface

// File: rtl/shift_in.sv
// Serial-to-parallel receiver: assembles MSB-first frames of exactly WIDTH bits,
// delivers good words and flags short or over-long frames.
module shift_in
    import shift_in_pkg::*;
#(
    parameter int WIDTH = LINK_WIDTH
) (
    input  logic     clk,
    input  logic     reset_n,
    shift_in_if.slave link
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_busy;
    logic             r_err_short;
    logic             r_err_overrun;

    logic [1:0]       w_state_nx;
    logic [CW-1:0]    w_cnt_nx;
    logic [WIDTH-1:0] w_shreg_nx;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_data_nx;
    logic             w_valid_nx;
    logic             w_err_short_nx;
    logic             w_err_overrun_nx;

    assign w_shifted = WIDTH'(shift_msb_first(32'(r_shreg), link.z_in));

    // Next-state, counter, shift register and status pulse decode.
    always_comb begin
        w_state_nx       = r_state;
        w_cnt_nx         = r_cnt;
        w_shreg_nx       = r_shreg;
        w_data_nx        = r_data;
        w_valid_nx       = 1'b0;
        w_err_short_nx   = 1'b0;
        w_err_overrun_nx = 1'b0;
        case (r_state)
            IDLE: begin
                if (link.fz_in) begin
                    w_shreg_nx = w_shifted;
                    w_cnt_nx   = CW'(1);
                    w_state_nx = RECV;
                end else begin
                    w_cnt_nx   = CW'(0);
                end
            end
            RECV: begin
                if (link.fz_in) begin
                    w_shreg_nx = w_shifted;
                    w_cnt_nx   = r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        w_state_nx = FULL;
                    end else begin
                        w_state_nx = RECV;
                    end
                end else begin
                    // Partial content stays in shreg; the next frame overwrites it fully.
                    w_err_short_nx = 1'b1;
                    w_cnt_nx       = CW'(0);
                    w_state_nx     = IDLE;
                end
            end
            FULL: begin
                if (link.fz_in) begin
                    w_err_overrun_nx = 1'b1;
                    w_state_nx       = DRAIN;
                end else begin
                    w_data_nx  = r_shreg;
                    w_valid_nx = 1'b1;
                    w_cnt_nx   = CW'(0);
                    w_state_nx = IDLE;
                end
            end
            DRAIN: begin
                if (link.fz_in) begin
                    w_state_nx = DRAIN;
                end else begin
                    w_cnt_nx   = CW'(0);
                    w_state_nx = IDLE;
                end
            end
            default: begin
                w_cnt_nx   = CW'(0);
                w_state_nx = IDLE;
            end
        endcase
    end

    // State and registered outputs; busy tracks the state being entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_cnt         <= CW'(0);
            r_shreg       <= WIDTH'(0);
            r_data        <= WIDTH'(0);
            r_valid       <= 1'b0;
            r_busy        <= 1'b0;
            r_err_short   <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_cnt         <= w_cnt_nx;
            r_shreg       <= w_shreg_nx;
            r_data        <= w_data_nx;
            r_valid       <= w_valid_nx;
            r_busy        <= (w_state_nx != IDLE);
            r_err_short   <= w_err_short_nx;
            r_err_overrun <= w_err_overrun_nx;
        end
    end

    assign link.data_out    = r_data;
    assign link.valid       = r_valid;
    assign link.busy        = r_busy;
    assign link.err_short   = r_err_short;
    assign link.err_overrun = r_err_overrun;

endmodule

// File: tb/tb_shift_in.sv
// Bench for shift_in: frame table, reset corner cases and random frames,
// all cross-checked each cycle against a frame-level reference model.
module tb_shift_in;
    import shift_in_pkg::*;

    localparam int W = LINK_WIDTH;

    typedef struct {
        logic [W-1:0] word;
        int           len;
        int           n_valid;
        int           n_short;
        int           n_over;
        logic [W-1:0] data;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;

    // Reference model state: bits of the current fz_in=1 run plus expected outputs.
    logic         q_bits[$];
    logic [W-1:0] exp_data;
    logic         exp_valid, exp_short, exp_over, exp_busy;

    vec_t tbl[7];

    always #5 clk = ~clk;

    shift_in_if #(.WIDTH(W)) link ();

    shift_in #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .link    (link)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        q_bits.delete();
        exp_data  = '0;
        exp_valid = 1'b0;
        exp_short = 1'b0;
        exp_over  = 1'b0;
        exp_busy  = 1'b0;
    endtask

    // A run of fz_in=1 samples is a frame; its fate is decided by its length.
    task automatic model_edge(input logic z, input logic fz);
        logic [W-1:0] word;
        exp_valid = 1'b0;
        exp_short = 1'b0;
        exp_over  = 1'b0;
        if (fz) begin
            if (q_bits.size() <= W) q_bits.push_back(z);
            if (q_bits.size() == W + 1 && z !== 1'bx) exp_over = 1'b1;
            if (q_bits.size() == W + 1) q_bits.push_back(1'b0);
            exp_busy = 1'b1;
        end else begin
            if (q_bits.size() > 0 && q_bits.size() < W) begin
                exp_short = 1'b1;
            end else if (q_bits.size() == W) begin
                word = '0;
                for (int i = 0; i < W; i++) word = (word << 1) | W'(q_bits[i]);
                exp_data  = word;
                exp_valid = 1'b1;
            end
            q_bits.delete();
            exp_busy = 1'b0;
        end
    endtask

    task automatic check_all();
        check("valid",       32'(link.valid),       32'(exp_valid));
        check("err_short",   32'(link.err_short),   32'(exp_short));
        check("err_overrun", 32'(link.err_overrun), 32'(exp_over));
        check("busy",        32'(link.busy),        32'(exp_busy));
        check("data_out",    32'(link.data_out),    32'(exp_data));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_data_out"},    32'(link.data_out),    32'h0);
        check({tag, "_valid"},       32'(link.valid),       32'h0);
        check({tag, "_busy"},        32'(link.busy),        32'h0);
        check({tag, "_err_short"},   32'(link.err_short),   32'h0);
        check({tag, "_err_overrun"}, 32'(link.err_overrun), 32'h0);
    endtask

    task automatic step(input logic z, input logic fz);
        link.z_in  = z;
        link.fz_in = fz;
        @(posedge clk);
        model_edge(z, fz);
        #1;
        check_all();
    endtask

    // Sends len bits MSB first (ones beyond W), then one fz_in=0 cycle; tallies DUT pulses.
    task automatic send_frame(input logic [W-1:0] word, input int len, input logic close,
                              output int nv, output int ns, output int no);
        nv = 0; ns = 0; no = 0;
        for (int i = 0; i < len; i++) begin
            step((i < W) ? word[W-1-i] : 1'b1, 1'b1);
            nv += int'(link.valid); ns += int'(link.err_short); no += int'(link.err_overrun);
        end
        if (close) begin
            step(1'($urandom), 1'b0);
            nv += int'(link.valid); ns += int'(link.err_short); no += int'(link.err_overrun);
        end
    endtask

    task automatic check_counts(input string tag, input int nv, input int ns, input int no,
                                input int ev, input int es, input int eo);
        check({tag, "_valid_pulses"},   32'(nv), 32'(ev));
        check({tag, "_short_pulses"},   32'(ns), 32'(es));
        check({tag, "_overrun_pulses"}, 32'(no), 32'(eo));
    endtask

    initial begin
        int nv, ns, no, len, gap;
        logic [W-1:0] rw;

        tbl[0] = '{24'hA5C3F0, 24, 1, 0, 0, 24'hA5C3F0};
        tbl[1] = '{24'h123456, 24, 1, 0, 0, 24'h123456};
        tbl[2] = '{24'hFFFFFF, 10, 0, 1, 0, 24'h123456};
        tbl[3] = '{24'h5A5A5A, 26, 0, 0, 1, 24'h123456};
        tbl[4] = '{24'hFFFFFF, 24, 1, 0, 0, 24'hFFFFFF};
        tbl[5] = '{24'h000001, 24, 1, 0, 0, 24'h000001};
        tbl[6] = '{24'hDEADBE, 24, 1, 0, 0, 24'hDEADBE};

        reset_n    = 1'b0;
        link.z_in  = 1'b0;
        link.fz_in = 1'b0;
        model_reset();
        #12;
        check_reset_values("reset");
        reset_n = 1'b1;

        for (int t = 0; t < 7; t++) begin
            send_frame(tbl[t].word, tbl[t].len, 1'b1, nv, ns, no);
            check_counts($sformatf("vec%0d", t), nv, ns, no,
                         tbl[t].n_valid, tbl[t].n_short, tbl[t].n_over);
            check($sformatf("vec%0d_data", t), 32'(link.data_out), 32'(tbl[t].data));
        end

        // Reset mid-frame, released while the frame is still running: 14 leftover bits end short.
        send_frame(24'hC0FFEE, 10, 1'b0, nv, ns, no);
        #2 reset_n = 1'b0;
        #1 check_reset_values("async_rst1");
        model_reset();
        #2 reset_n = 1'b1;
        send_frame(24'hC0FFEE, 14, 1'b1, nv, ns, no);
        check_counts("rst_inflight", nv, ns, no, 0, 1, 0);

        // Reset after 12 bits, then a clean frame.
        send_frame(24'h0F0F0F, 12, 1'b0, nv, ns, no);
        #2 reset_n = 1'b0;
        link.fz_in = 1'b0;
        #1 check_reset_values("async_rst2");
        model_reset();
        #2 reset_n = 1'b1;
        send_frame(24'h0F0F0F, 24, 1'b1, nv, ns, no);
        check_counts("post_rst", nv, ns, no, 1, 0, 0);
        check("post_rst_data", 32'(link.data_out), 32'h0F0F0F);

        for (int f = 0; f < 60; f++) begin
            rw  = W'($urandom);
            len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, W + 4)) : W;
            for (int i = 0; i < len; i++) step(1'($urandom), 1'b1);
            gap = int'($urandom_range(1, 3));
            for (int g = 0; g < gap; g++) step(1'($urandom), 1'b0);
            if (rw[0]) step(rw[1], 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
